// File: rtl/dcu_smu_resp.sv
// DCU-side responder for SMU spill/fill traffic: an in-order request queue feeding
// the dcache array port, with at most one fill outstanding and flush of unissued work.
module dcu_smu_resp #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        smu_ld,
  input  logic        smu_st,
  input  logic        smu_na_st,
  input  logic [31:0] smu_addr,
  input  logic [31:0] smu_data,
  input  logic        smu_flush,
  output logic        smu_stall,
  output logic        smu_data_vld,
  output logic [31:0] dcu_data,
  output logic        dc_req,
  output logic        dc_we,
  output logic        dc_na,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_gnt,
  input  logic        dc_rvld,
  input  logic [31:0] dc_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic        we;
    logic        na;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t             queue_q [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ld_pend;
  logic               drop;
  logic               accept;
  logic               pop;
  logic               fill_done;
  logic               deliver;

  // Stall is a function of registered state only, so the SMU sees it early in the cycle.
  assign smu_stall = (count >= CNT_W'(DEPTH - 1)) | (ld_pend && (count != '0));
  assign accept    = (smu_ld | smu_st) && !smu_stall && !smu_flush;

  assign head      = queue_q[rd_ptr];
  assign dc_req    = (count != '0) && !ld_pend;
  assign pop       = dc_req && dc_gnt;
  assign fill_done = dc_rvld && ld_pend;
  assign deliver   = fill_done && !drop && !smu_flush;

  // Array-side fields are qualified by dc_req so they read as zero while idle.
  assign dc_we    = dc_req & head.we;
  assign dc_na    = dc_req & head.na;
  assign dc_addr  = dc_req ? head.addr : '0;
  assign dc_wdata = dc_req ? head.data : '0;

  // NOTE: queue storage is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (accept) begin
      queue_q[wr_ptr] <= '{we: smu_st && !smu_ld, na: smu_na_st, addr: smu_addr, data: smu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ld_pend      <= 1'b0;
      drop         <= 1'b0;
      smu_data_vld <= 1'b0;
      dcu_data     <= '0;
    end else begin
      smu_data_vld <= deliver;
      if (deliver) dcu_data <= dc_rdata;

      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);

      // Flush empties the queue; a grant seen in the same cycle has already left it.
      if (smu_flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({accept, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      if (pop && !head.we)  ld_pend <= 1'b1;
      else if (fill_done)   ld_pend <= 1'b0;

      // A flushed fill is still awaited so the array handshake stays balanced.
      if (fill_done)                 drop <= 1'b0;
      else if (smu_flush && ld_pend) drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcu_smu_resp.sv
// Scoreboard bench for dcu_smu_resp: expected array issues and fill returns are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_dcu_smu_resp;

  logic        clk;
  logic        reset;
  logic        smu_ld, smu_st, smu_na_st, smu_flush;
  logic [31:0] smu_addr, smu_data;
  logic        smu_stall, smu_data_vld;
  logic [31:0] dcu_data;
  logic        dc_req, dc_we, dc_na;
  logic [31:0] dc_addr, dc_wdata;
  logic        dc_gnt, dc_rvld;
  logic [31:0] dc_rdata;

  typedef struct packed {
    logic        we;
    logic        na;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        issue_q [$];
  logic [31:0] fill_q  [$];

  int n_tests = 0;
  int n_fail  = 0;

  dcu_smu_resp #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .smu_ld(smu_ld), .smu_st(smu_st), .smu_na_st(smu_na_st),
    .smu_addr(smu_addr), .smu_data(smu_data), .smu_flush(smu_flush),
    .smu_stall(smu_stall), .smu_data_vld(smu_data_vld), .dcu_data(dcu_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_na(dc_na),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvld(dc_rvld), .dc_rdata(dc_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request cycle; exp_acc says whether the bench expects it to be taken.
  task automatic send(input logic ld, input logic st, input logic na,
                      input logic [31:0] addr, input logic [31:0] data, input bit exp_acc);
    check("stall_at_send", {31'd0, smu_stall}, {31'd0, !exp_acc});
    smu_ld = ld; smu_st = st; smu_na_st = na; smu_addr = addr; smu_data = data;
    if (exp_acc) issue_q.push_back('{we: st && !ld, na: na, addr: addr, data: data});
    tick();
    smu_ld = 1'b0; smu_st = 1'b0; smu_na_st = 1'b0; smu_addr = '0; smu_data = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (!dc_req) break;
      tick();
    end
    check("drain_done", {31'd0, dc_req}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, smu_stall}, 32'd0);
    check({tag, "_dvld"},  {31'd0, smu_data_vld}, 32'd0);
    check({tag, "_dcu"},   dcu_data, 32'd0);
    check({tag, "_req"},   {31'd0, dc_req}, 32'd0);
    check({tag, "_we"},    {31'd0, dc_we}, 32'd0);
    check({tag, "_na"},    {31'd0, dc_na}, 32'd0);
    check({tag, "_addr"},  dc_addr, 32'd0);
    check({tag, "_wdata"}, dc_wdata, 32'd0);
  endtask

  // Monitor: every granted issue and every fill pulse must match the scoreboard head.
  always @(negedge clk) begin
    req_t        e;
    logic [31:0] f;
    if (dc_req && dc_gnt) begin
      if (issue_q.size() == 0) begin
        check("unexpected_issue", dc_addr, 32'hFFFF_FFFF);
      end else begin
        e = issue_q.pop_front();
        check("issue_we",   {31'd0, dc_we}, {31'd0, e.we});
        check("issue_na",   {31'd0, dc_na}, {31'd0, e.na});
        check("issue_addr", dc_addr, e.addr);
        if (e.we) check("issue_wdata", dc_wdata, e.data);
      end
    end
    if (smu_data_vld) begin
      if (fill_q.size() == 0) begin
        check("unexpected_fill", dcu_data, 32'hFFFF_FFFF);
      end else begin
        f = fill_q.pop_front();
        check("fill_data", dcu_data, f);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; smu_ld = 0; smu_st = 0; smu_na_st = 0; smu_flush = 0;
    smu_addr = '0; smu_data = '0; dc_gnt = 0; dc_rvld = 0; dc_rdata = '0;
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;
    tick();
    check_all_zero("post_rst");

    // Single store with immediate grant.
    dc_gnt = 1'b1;
    send(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD, 1'b1);
    check("st_req",  {31'd0, dc_req}, 32'd1);
    check("st_we",   {31'd0, dc_we}, 32'd1);
    check("st_addr", dc_addr, 32'h100);
    tick();
    check("st_done", {31'd0, dc_req}, 32'd0);

    // Single load, fill returns later.
    send(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1);
    check("ld_req",  {31'd0, dc_req}, 32'd1);
    check("ld_we",   {31'd0, dc_we}, 32'd0);
    check("ld_addr", dc_addr, 32'h200);
    tick();
    check("ld_pend_noreq", {31'd0, dc_req}, 32'd0);
    tick(); tick();
    dc_rvld = 1'b1; dc_rdata = 32'h1234; fill_q.push_back(32'h1234);
    tick();
    dc_rvld = 1'b0; dc_rdata = '0;
    check("fill_vld", {31'd0, smu_data_vld}, 32'd1);
    check("fill_dcu", dcu_data, 32'h1234);
    tick();
    check("fill_pulse_end", {31'd0, smu_data_vld}, 32'd0);
    check("fill_hold", dcu_data, 32'h1234);

    // Fill the queue with the array stalled; fourth request must be ignored.
    dc_gnt = 1'b0;
    send(1'b0, 1'b1, 1'b0, 32'h400, 32'h11, 1'b1);
    send(1'b0, 1'b1, 1'b1, 32'h404, 32'h22, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h408, 32'h33, 1'b1);
    check("full_head_addr", dc_addr, 32'h400);
    send(1'b0, 1'b1, 1'b0, 32'h40C, 32'h44, 1'b0);
    dc_gnt = 1'b1;
    wait_idle();
    check("full_drained_stall", {31'd0, smu_stall}, 32'd0);

    // Store behind a load is held until the fill returns.
    send(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h504, 32'hCAFE, 1'b1);
    check("order_stall", {31'd0, smu_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("order_hold", {31'd0, dc_req}, 32'd0);
      tick();
    end
    dc_rvld = 1'b1; dc_rdata = 32'hBEEF; fill_q.push_back(32'hBEEF);
    tick();
    dc_rvld = 1'b0; dc_rdata = '0;
    check("order_fill", {31'd0, smu_data_vld}, 32'd1);
    check("order_st_req", {31'd0, dc_req}, 32'd1);
    check("order_st_addr", dc_addr, 32'h504);
    wait_idle();

    // Flush with two queued stores and a pending load.
    dc_gnt = 1'b0;
    send(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h604, 32'h66, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h608, 32'h77, 1'b1);
    dc_gnt = 1'b1;
    tick();
    dc_gnt = 1'b0;
    check("fl_pend_noreq", {31'd0, dc_req}, 32'd0);
    smu_flush = 1'b1;
    issue_q.delete();
    tick();
    smu_flush = 1'b0;
    dc_gnt = 1'b1;
    check("fl_req", {31'd0, dc_req}, 32'd0);
    check("fl_stall", {31'd0, smu_stall}, 32'd0);
    tick();
    check("fl_req2", {31'd0, dc_req}, 32'd0);
    dc_rvld = 1'b1; dc_rdata = 32'h5555;
    tick();
    dc_rvld = 1'b0; dc_rdata = '0;
    check("fl_drop_vld", {31'd0, smu_data_vld}, 32'd0);
    check("fl_drop_dcu", dcu_data, 32'hBEEF);
    tick();
    check("fl_drop_vld2", {31'd0, smu_data_vld}, 32'd0);
    send(1'b0, 1'b1, 1'b0, 32'h700, 32'h88, 1'b1);
    check("fl_recover_addr", dc_addr, 32'h700);
    wait_idle();

    // Reset with a load pending, then a stray fill.
    send(1'b1, 1'b0, 1'b0, 32'h800, 32'h0, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst_pend");
    dc_rvld = 1'b1; dc_rdata = 32'h9999;
    tick();
    dc_rvld = 1'b0; dc_rdata = '0;
    check("stray_vld", {31'd0, smu_data_vld}, 32'd0);
    check("stray_dcu", dcu_data, 32'd0);

    // Reset with three queued stores.
    dc_gnt = 1'b0;
    send(1'b0, 1'b1, 1'b0, 32'h900, 32'h1, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h904, 32'h2, 1'b1);
    send(1'b0, 1'b1, 1'b0, 32'h908, 32'h3, 1'b1);
    reset = 1'b1;
    tick();
    issue_q.delete();
    check_all_zero("rst_full");
    reset = 1'b0;
    dc_gnt = 1'b1;
    tick();
    check("rst_full_req", {31'd0, dc_req}, 32'd0);
    tick();

    check("issue_q_empty", issue_q.size(), 32'd0);
    check("fill_q_empty",  fill_q.size(),  32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
